dc_remove_ma: RTL and testbench

- Parametrised moving-average DC remover for the FM demodulator datapath, replacing the fixed 128-sample single-channel stage.
- Keeps a running sum of the last DEPTH accepted samples per channel and outputs the sample minus the floor mean, the mean itself, or the raw sample.
- Adds selectable mode, saturation, multi-channel operation (I/Q), a flush/clear sequencer and a primed indication.
- Sits between the merge stage and the demodulator core; streaming with no backpressure.

---
 rtl/dc_remove_ma.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_dc_remove_ma.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dc_remove_ma.sv
// dc_remove_ma: moving-average DC remover for NCH parallel channels.
// Keeps the last DEPTH = 2^LOG2_DEPTH accepted samples of every channel in
// one shared buffer together with a running sum per channel, and outputs the
// sample minus the floor mean (saturated), the mean itself, or the raw sample.
// Fixed latency of two cycles from an accepted sample to its valid_o.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   valid_i    sample strobe, accepted when busy_o is low
//   data_i     packed samples, channel c at [c*WIDTH +: WIDTH]
//   mode_i     00 bypass, 01/11 DC-removed, 10 mean
//   flush_i    restart the window (clears buffer, drops in-flight samples)
//   valid_o    one-cycle result strobe
//   data_o     packed results, held while valid_o is low
//   sat_o      any channel clamped (meaningful with valid_o)
//   primed_o   window holds DEPTH real samples
//   busy_o     buffer clear in progress, inputs are dropped
module dc_remove_ma #(
  parameter int WIDTH      = 16,
  parameter int LOG2_DEPTH = 7,
  parameter int NCH        = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic [NCH*WIDTH-1:0] data_i,
  input  logic [1:0]           mode_i,
  input  logic                 flush_i,
  output logic                 valid_o,
  output logic [NCH*WIDTH-1:0] data_o,
  output logic                 sat_o,
  output logic                 primed_o,
  output logic                 busy_o
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int DW    = NCH * WIDTH;
  localparam int SW    = WIDTH + LOG2_DEPTH;
  localparam logic [LOG2_DEPTH-1:0] PTR_ONE  = LOG2_DEPTH'(1);
  localparam logic [LOG2_DEPTH-1:0] PTR_LAST = LOG2_DEPTH'(DEPTH - 1);
  localparam logic signed [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [LOG2_DEPTH-1:0] clr_cnt_q, clr_cnt_d;
  logic [LOG2_DEPTH-1:0] wptr_q, wptr_d;
  logic [LOG2_DEPTH-1:0] fill_cnt_q, fill_cnt_d;
  logic                  accept, last;
  logic                  mem_we;
  logic [LOG2_DEPTH-1:0] mem_addr;
  logic [DW-1:0]         mem_wdata;
  logic [DW-1:0]         mem_q [DEPTH];

  logic                  s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
  logic [1:0]            s1_mode_q, s1_mode_d;
  logic [DW-1:0]         s1_x_q, s1_x_d, s1_old_q, s1_old_d;
  logic                  s2_vld_q, s2_vld_d, s2_last_q, s2_last_d;
  logic [1:0]            s2_mode_q, s2_mode_d;
  logic [DW-1:0]         s2_x_q, s2_x_d;
  logic                  valid_q, valid_d, sat_q, sat_d, primed_q, primed_d;
  logic [DW-1:0]         data_q, data_d;
  logic [DW-1:0]         res_all;
  logic [NCH-1:0]        sat_all;

  // Sequencer: clear walk, fill counting, write pointer and buffer port.
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    wptr_d     = wptr_q;
    fill_cnt_d = fill_cnt_q;
    accept     = 1'b0;
    last       = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = wptr_q;
    mem_wdata  = data_i;
    if (flush_i) begin
      state_d    = ST_CLEAR;
      clr_cnt_d  = '0;
      wptr_d     = '0;
      fill_cnt_d = '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          mem_we     = 1'b1;
          mem_addr   = clr_cnt_q;
          mem_wdata  = '0;
          wptr_d     = '0;
          fill_cnt_d = '0;
          if (clr_cnt_q == PTR_LAST) begin
            state_d   = ST_FILL;
            clr_cnt_d = '0;
          end else begin
            clr_cnt_d = clr_cnt_q + PTR_ONE;
          end
        end
        ST_FILL, ST_RUN: begin
          if (valid_i) begin
            accept = 1'b1;
            mem_we = 1'b1;
            wptr_d = wptr_q + PTR_ONE;
            if (state_q == ST_FILL) begin
              fill_cnt_d = fill_cnt_q + PTR_ONE;
              // The DEPTH-th sample completes the window.
              if (fill_cnt_q == PTR_LAST) begin
                state_d = ST_RUN;
                last    = 1'b1;
              end else begin
                state_d = ST_FILL;
              end
            end else begin
              fill_cnt_d = fill_cnt_q;
            end
          end else begin
            wptr_d = wptr_q;
          end
        end
        default: begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      endcase
    end
  end

  // Pipeline stages and output register next values.
  always_comb begin
    s1_vld_d  = accept;
    s1_last_d = last;
    if (accept) begin
      s1_x_d    = data_i;
      s1_old_d  = mem_q[wptr_q];
      s1_mode_d = mode_i;
    end else begin
      s1_x_d    = s1_x_q;
      s1_old_d  = s1_old_q;
      s1_mode_d = s1_mode_q;
    end
    // A flush kills whatever sits in either stage.
    s2_vld_d  = s1_vld_q & ~flush_i;
    s2_last_d = s1_last_q;
    if (s1_vld_q) begin
      s2_x_d    = s1_x_q;
      s2_mode_d = s1_mode_q;
    end else begin
      s2_x_d    = s2_x_q;
      s2_mode_d = s2_mode_q;
    end
    valid_d = s2_vld_q & ~flush_i;
    if (valid_d) begin
      data_d = res_all;
      sat_d  = |sat_all;
    end else begin
      data_d = data_q;
      sat_d  = sat_q;
    end
    if (flush_i) begin
      primed_d = 1'b0;
    end else if (valid_d && s2_last_q) begin
      primed_d = 1'b1;
    end else begin
      primed_d = primed_q;
    end
  end

  // Control, pipeline and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      clr_cnt_q  <= '0;
      wptr_q     <= '0;
      fill_cnt_q <= '0;
      s1_vld_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_mode_q  <= 2'b00;
      s1_x_q     <= '0;
      s1_old_q   <= '0;
      s2_vld_q   <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_mode_q  <= 2'b00;
      s2_x_q     <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      sat_q      <= 1'b0;
      primed_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      wptr_q     <= wptr_d;
      fill_cnt_q <= fill_cnt_d;
      s1_vld_q   <= s1_vld_d;
      s1_last_q  <= s1_last_d;
      s1_mode_q  <= s1_mode_d;
      s1_x_q     <= s1_x_d;
      s1_old_q   <= s1_old_d;
      s2_vld_q   <= s2_vld_d;
      s2_last_q  <= s2_last_d;
      s2_mode_q  <= s2_mode_d;
      s2_x_q     <= s2_x_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      sat_q      <= sat_d;
      primed_q   <= primed_d;
    end
  end

  // Sample buffer; its contents are initialised by the CLEAR walk.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_addr] <= mem_wdata;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic signed [SW-1:0]    sum_q, sum_d;
    logic signed [WIDTH-1:0] x1, old, x2, mean, res;
    logic signed [WIDTH:0]   diff;
    logic                    sat;

    assign x1   = s1_x_q[g*WIDTH +: WIDTH];
    assign old  = s1_old_q[g*WIDTH +: WIDTH];
    assign x2   = s2_x_q[g*WIDTH +: WIDTH];
    // Floor mean; the shifted sum always fits in WIDTH bits.
    assign mean = WIDTH'(sum_q >>> LOG2_DEPTH);
    assign diff = $signed({x2[WIDTH-1], x2}) - $signed({mean[WIDTH-1], mean});

    // Running sum: add the new sample, drop the one it overwrote.
    always_comb begin
      if (flush_i || (state_q == ST_CLEAR)) begin
        sum_d = '0;
      end else if (s1_vld_q) begin
        sum_d = sum_q + $signed({{LOG2_DEPTH{x1[WIDTH-1]}}, x1})
                      - $signed({{LOG2_DEPTH{old[WIDTH-1]}}, old});
      end else begin
        sum_d = sum_q;
      end
    end

    // Running sum register.
    always_ff @(posedge clk) begin
      if (rst) begin
        sum_q <= '0;
      end else begin
        sum_q <= sum_d;
      end
    end

    // Result select and clamp of the WIDTH+1 bit difference.
    always_comb begin
      res = x2;
      sat = 1'b0;
      case (s2_mode_q)
        2'b00: begin
          res = x2;
        end
        2'b10: begin
          res = mean;
        end
        default: begin
          if (diff[WIDTH] != diff[WIDTH-1]) begin
            sat = 1'b1;
            res = diff[WIDTH] ? S_MIN : S_MAX;
          end else begin
            res = diff[WIDTH-1:0];
          end
        end
      endcase
    end

    assign res_all[g*WIDTH +: WIDTH] = res;
    assign sat_all[g]                = sat;
  end

  assign valid_o  = valid_q;
  assign data_o   = data_q;
  assign sat_o    = sat_q;
  assign primed_o = primed_q;
  assign busy_o   = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_dc_remove_ma.sv
// Self-checking bench for dc_remove_ma (WIDTH=16, LOG2_DEPTH=3, NCH=2).
// The reference keeps the window as a queue of the last 8 accepted samples
// per channel and recomputes the sum from scratch; expectations are stored
// per clock edge and compared on every edge, plus literal scenario checks.
module tb_dc_remove_ma;
  localparam int MAXE = 2048;
  localparam int INF  = 1 << 30;

  logic        clk = 1'b0;
  logic        rst = 1'b1, valid_i = 1'b0, flush_i = 1'b0;
  logic [31:0] data_i = 32'd0;
  logic [1:0]  mode_i = 2'b00;
  logic        valid_o, sat_o, primed_o, busy_o;
  logic [31:0] data_o;

  always #5 clk = ~clk;

  dc_remove_ma #(.WIDTH(16), .LOG2_DEPTH(3), .NCH(2)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .data_i(data_i), .mode_i(mode_i),
    .flush_i(flush_i), .valid_o(valid_o), .data_o(data_o), .sat_o(sat_o),
    .primed_o(primed_o), .busy_o(busy_o)
  );

  int n_chk = 0, n_fail = 0, edge_n = 0;
  bit exp_valid [MAXE];
  bit exp_busy  [MAXE];
  bit exp_rst   [MAXE];
  bit exp_sat   [MAXE];
  int exp_d0    [MAXE];
  int exp_d1    [MAXE];
  int m_clr = 0, m_cnt = 0, m_prime_edge = INF;
  int win0[$], win1[$];
  int cap0[$], cap1[$];
  bit capp[$], caps[$];
  int c_d0 = 0, c_d1 = 0;
  bit c_sat = 1'b0;

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d, required %0d", nm, edge_n, act, exp);
    end
  endtask

  function automatic int floor8(input int s);
    if (s >= 0) return s / 8;
    else        return -((-s + 7) / 8);
  endfunction

  task automatic calc(input int x, input int mean, input logic [1:0] md, output int r, output bit s);
    s = 1'b0;
    if (md == 2'b00)      r = x;
    else if (md == 2'b10) r = mean;
    else begin
      r = x - mean;
      if (r > 32767)       begin r = 32767;  s = 1'b1; end
      else if (r < -32768) begin r = -32768; s = 1'b1; end
    end
  endtask

  task automatic reset_window();
    win0.delete(); win1.delete();
    for (int i = 0; i < 8; i++) begin win0.push_back(0); win1.push_back(0); end
    m_cnt = 0;
  endtask

  // Predict the effect of the coming clock edge for the inputs just driven.
  task automatic model_step(input bit r, input bit v, input logic [15:0] d0, input logic [15:0] d1,
                            input logic [1:0] md, input bit f);
    int e, s0, s1, r0, r1;
    bit busy_now, st0, st1;
    e = edge_n + 1;
    if (e + 2 >= MAXE) return;
    exp_valid[e + 2] = 1'b0;
    exp_rst[e] = r;
    if (r || f) begin
      m_clr = 8;
      exp_busy[e] = 1'b1;
      exp_valid[e] = 1'b0;
      exp_valid[e + 1] = 1'b0;
      m_prime_edge = INF;
      reset_window();
    end else begin
      busy_now = (m_clr > 0);
      if (busy_now) m_clr--;
      exp_busy[e] = (m_clr > 0);
      if (v && !busy_now) begin
        win0.push_back(int'($signed(d0))); void'(win0.pop_front());
        win1.push_back(int'($signed(d1))); void'(win1.pop_front());
        s0 = 0; s1 = 0;
        foreach (win0[i]) s0 += win0[i];
        foreach (win1[i]) s1 += win1[i];
        calc(int'($signed(d0)), floor8(s0), md, r0, st0);
        calc(int'($signed(d1)), floor8(s1), md, r1, st1);
        exp_valid[e + 2] = 1'b1;
        exp_d0[e + 2] = r0;
        exp_d1[e + 2] = r1;
        exp_sat[e + 2] = st0 | st1;
        m_cnt++;
        if (m_cnt == 8) m_prime_edge = e + 2;
      end
    end
  endtask

  task automatic drive(input bit r, input bit v, input int d0, input int d1, input logic [1:0] md, input bit f);
    rst = r; valid_i = v; flush_i = f; mode_i = md;
    data_i = {d1[15:0], d0[15:0]};
    model_step(r, v, data_i[15:0], data_i[31:16], md, f);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 2'b00, 1'b0);
  endtask

  task automatic clear_caps();
    cap0.delete(); cap1.delete(); capp.delete(); caps.delete();
  endtask

  // Per-edge comparison of every output against the reference.
  initial begin
    forever begin
      @(posedge clk);
      edge_n++;
      #1;
      if (edge_n < MAXE) begin
        if (exp_rst[edge_n]) begin c_d0 = 0; c_d1 = 0; c_sat = 1'b0; end
        if (exp_valid[edge_n]) begin
          c_d0 = exp_d0[edge_n]; c_d1 = exp_d1[edge_n]; c_sat = exp_sat[edge_n];
        end
        chk("valid_o", {31'd0, valid_o}, {31'd0, exp_valid[edge_n]});
        chk("busy_o", {31'd0, busy_o}, {31'd0, exp_busy[edge_n]});
        chk("primed_o", {31'd0, primed_o}, (edge_n >= m_prime_edge) ? 32'sd1 : 32'sd0);
        chk("data_o ch0", 32'($signed(data_o[15:0])), c_d0);
        chk("data_o ch1", 32'($signed(data_o[31:16])), c_d1);
        chk("sat_o", {31'd0, sat_o}, {31'd0, c_sat});
        if (valid_o === 1'b1) begin
          cap0.push_back(int'($signed(data_o[15:0])));
          cap1.push_back(int'($signed(data_o[31:16])));
          capp.push_back(primed_o);
          caps.push_back(sat_o);
        end
      end
    end
  end

  initial begin
    int nb;
    int lit[10];
    int v, d0, d1;
    bit r, f;
    lit = '{875, 750, 625, 500, 375, 250, 125, 0, 0, 0};

    // Reset with valid and data present.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 111, 222, 2'b01, 1'b0);
    nb = (busy_o === 1'b1) ? 1 : 0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, (i < 8), 111, 222, 2'b01, 1'b0);
      if (busy_o === 1'b1) nb++;
    end
    chk("reset busy cycles", nb, 8);
    chk("reset primed", {31'd0, primed_o}, 0);
    chk("reset data", data_o, 0);
    chk("reset no output", cap0.size(), 0);

    // Constant DC, mode 01.
    clear_caps();
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 1000, -1000, 2'b01, 1'b0);
    idle(3);
    chk("dc count", cap0.size(), 10);
    for (int i = 0; i < 10 && i < cap0.size(); i++) begin
      chk("dc ch0", cap0[i], lit[i]);
      chk("dc ch1", cap1[i], -lit[i]);
    end
    if (cap0.size() >= 8) begin
      chk("primed before 8th", {31'd0, capp[6]}, 0);
      chk("primed at 8th", {31'd0, capp[7]}, 1);
    end

    // Mode switching.
    clear_caps();
    drive(1'b0, 1'b1, 1000, -1000, 2'b10, 1'b0);
    drive(1'b0, 1'b1, 1234, -5, 2'b00, 1'b0);
    drive(1'b0, 1'b1, 1000, -1000, 2'b10, 1'b0);
    idle(3);
    chk("mode count", cap0.size(), 3);
    if (cap0.size() == 3) begin
      chk("mean ch0", cap0[0], 1000);   chk("mean ch1", cap1[0], -1000);
      chk("bypass ch0", cap0[1], 1234); chk("bypass ch1", cap1[1], -5);
      chk("mean2 ch0", cap0[2], 1029);  chk("mean2 ch1", cap1[2], -876);
    end

    // Saturation.
    chk("model floor", floor8(-196609), -24577);
    drive(1'b0, 1'b0, 0, 0, 2'b00, 1'b1);
    idle(9);
    clear_caps();
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, -32768, 0, 2'b01, 1'b0);
    drive(1'b0, 1'b1, 32767, 0, 2'b01, 1'b0);
    idle(3);
    chk("sat count", cap0.size(), 9);
    if (cap0.size() == 9) begin
      chk("sat value", cap0[8], 32767);
      chk("sat flag", {31'd0, caps[8]}, 1);
      chk("no sat before", {31'd0, caps[7]}, 0);
    end

    // Flush with two samples in flight.
    clear_caps();
    drive(1'b0, 1'b1, 500, 500, 2'b01, 1'b0);
    drive(1'b0, 1'b1, 500, 500, 2'b01, 1'b0);
    drive(1'b0, 1'b1, 500, 500, 2'b01, 1'b1);
    nb = (busy_o === 1'b1) ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      idle(1);
      if (busy_o === 1'b1) nb++;
    end
    chk("flush busy cycles", nb, 8);
    chk("flush dropped", cap0.size(), 0);
    chk("flush primed", {31'd0, primed_o}, 0);
    drive(1'b0, 1'b1, 1000, -1000, 2'b01, 1'b0);
    idle(3);
    chk("post flush count", cap0.size(), 1);
    if (cap0.size() == 1) begin
      chk("post flush ch0", cap0[0], 875);
      chk("post flush ch1", cap1[0], -875);
    end

    // Gapped input, offers during clear are dropped.
    clear_caps();
    drive(1'b0, 1'b1, 777, 777, 2'b01, 1'b1);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 777, 777, 2'b01, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 1000, -1000, 2'b01, 1'b0);
      idle(2);
    end
    idle(3);
    chk("gap count", cap0.size(), 10);
    for (int i = 0; i < 10 && i < cap0.size(); i++) begin
      chk("gap ch0", cap0[i], lit[i]);
      chk("gap ch1", cap1[i], -lit[i]);
    end

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 299) == 0);
      f = ($urandom_range(0, 49) == 0);
      v = ($urandom_range(0, 9) < 7) ? 1 : 0;
      if ($urandom_range(0, 3) == 0) begin
        d0 = ($urandom_range(0, 1) == 1) ? 32767 : -32768;
        d1 = ($urandom_range(0, 1) == 1) ? 32767 : -32768;
      end else begin
        d0 = int'($urandom_range(0, 65535)) - 32768;
        d1 = int'($urandom_range(0, 65535)) - 32768;
      end
      drive(r, v[0], d0, d1, 2'($urandom_range(0, 3)), f);
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
